// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS32 control path: opcodes, ALUOp,
// datapath mux selects and the main control state enum.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADDR = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_REXEC   = 4'd6,
        ST_RWB     = 4'd7,
        ST_IEXEC   = 4'd8,
        ST_IWB     = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_JUMP    = 4'd11
    } state_t;

    function automatic logic is_known_opcode(input logic [5:0] op);
        return (op == OP_R) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS32 datapath: sequences each
// instruction, drives datapath enables/selects and counts retirements.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_reg, state_next;
    logic             ready;
    logic             retire_next;
    logic             illegal_next;
    logic             illegal_reg;
    logic             done_reg;
    logic [CNT_W-1:0] count_reg;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_FETCH;
            illegal_reg <= 1'b0;
            done_reg    <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
            done_reg    <= retire_next;
            if (retire_next) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = ST_FETCH;
        retire_next   = 1'b0;
        illegal_next  = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;

        case (state_reg)
            ST_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                ir_write   = ready;
                pc_write   = ready;
                state_next = ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: state_next = ST_MEMADDR;
                    OP_R:         state_next = ST_REXEC;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_J:         state_next = ST_JUMP;
                    OP_ADDI:      state_next = ST_IEXEC;
                    default:      state_next = ST_FETCH;
                endcase
                illegal_next = !is_known_opcode(opcode);
            end
            ST_MEMADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                state_next = ready ? ST_MEMWB : ST_MEMRD;
            end
            ST_MEMWB: begin
                reg_write   = 1'b1;
                mem_to_reg  = 1'b1;
                retire_next = 1'b1;
            end
            ST_MEMWR: begin
                mem_write   = 1'b1;
                i_or_d      = 1'b1;
                retire_next = ready;
                state_next  = ready ? ST_FETCH : ST_MEMWR;
            end
            ST_REXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                state_next = ST_RWB;
            end
            ST_RWB: begin
                reg_write   = 1'b1;
                reg_dst     = 1'b1;
                retire_next = 1'b1;
            end
            ST_IEXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = ST_IWB;
            end
            ST_IWB: begin
                reg_write   = 1'b1;
                retire_next = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire_next   = 1'b1;
            end
            ST_JUMP: begin
                pc_write    = 1'b1;
                pc_source   = PCSRC_JUMP;
                retire_next = 1'b1;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    assign illegal_op  = illegal_reg;
    assign instr_done  = done_reg;
    assign instr_count = count_reg;

endmodule
